tlc_phase_scheduler: RTL and testbench

Two-approach traffic-light phase scheduler for the intersection controller. It shares the intersection between the north-south (NS) and east-west (EW) approaches. Each approach keeps a saturating 0–4 demand counter that counts waiting ticks while the approach is not green. A six-state FSM sequences green, yellow and all-red phases from those counts and a phase timer. All timing is in units of the external `tick` enable, not raw clocks.

---
 rtl/tlc_pkg.sv | 20 ++
 rtl/approach_wait_counter.sv | 26 ++
 rtl/tlc_phase_scheduler.sv | 100 ++++++++++
 tb/tb_tlc_phase_scheduler.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// Shared types and constants for the two-approach traffic-light phase scheduler.
package tlc_pkg;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        RED_TO_EW = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        RED_TO_NS = 3'd5
    } phase_t;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    localparam logic [2:0] WAIT_MAX  = 3'd4;
    localparam logic [3:0] TIMER_MAX = 4'd15;

endpackage

// File: rtl/approach_wait_counter.sv
// Saturating 0..4 demand counter for one approach; counts waiting ticks while not green.
module approach_wait_counter
    import tlc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       car,
    input  logic       is_green,
    input  logic       clear,
    output logic [2:0] count
);

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 3'd0;
        end else if (clear) begin
            count <= 3'd0;
        end else if (tick && car && !is_green) begin
            count <= (count >= WAIT_MAX) ? WAIT_MAX : count + 3'd1;
        end
    end

endmodule

// File: rtl/tlc_phase_scheduler.sv
// Six-state NS/EW phase scheduler: FSM, tick-based phase timer and light decode.
module tlc_phase_scheduler
    import tlc_pkg::*;
#(
    parameter int MIN_GREEN     = 4,
    parameter int MAX_GREEN     = 12,
    parameter int YELLOW_TICKS  = 3,
    parameter int ALL_RED_TICKS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       ns_car,
    input  logic       ew_car,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic [2:0] ns_wait,
    output logic [2:0] ew_wait,
    output logic [2:0] phase
);

    localparam logic [4:0] MIN_N    = 5'(MIN_GREEN);
    localparam logic [4:0] MAX_N    = 5'(MAX_GREEN);
    localparam logic [4:0] YELLOW_N = 5'(YELLOW_TICKS);
    localparam logic [4:0] RED_N    = 5'(ALL_RED_TICKS);

    phase_t     state, next_state;
    logic [3:0] timer;
    logic [4:0] n;
    logic       state_change;

    // n counts the current tick too, so it can reach 16 once the timer saturates
    assign n            = {1'b0, timer} + 5'd1;
    assign state_change = (next_state != state);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= NS_GREEN;
            timer <= 4'd0;
        end else begin
            state <= next_state;
            if (state_change) begin
                timer <= 4'd0;
            end else if (tick && timer != TIMER_MAX) begin
                timer <= timer + 4'd1;
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        next_state = state;
        case (state)
            NS_GREEN:  if (tick && ((n >= MIN_N && ew_wait == WAIT_MAX) ||
                                    (n >= MAX_N && ew_wait != 3'd0)))     next_state = NS_YELLOW;
            NS_YELLOW: if (tick && n == YELLOW_N)                          next_state = RED_TO_EW;
            RED_TO_EW: if (tick && n == RED_N)                             next_state = EW_GREEN;
            EW_GREEN:  if (tick && ((n >= MIN_N && ns_wait == WAIT_MAX) ||
                                    (n >= MAX_N && ns_wait != 3'd0)))     next_state = EW_YELLOW;
            EW_YELLOW: if (tick && n == YELLOW_N)                          next_state = RED_TO_NS;
            RED_TO_NS: if (tick && n == RED_N)                             next_state = NS_GREEN;
            default:                                                       next_state = NS_GREEN;
        endcase
    end

    always_comb begin
        ns_light = LIGHT_RED;
        ew_light = LIGHT_RED;
        case (state)
            NS_GREEN:  ns_light = LIGHT_GREEN;
            NS_YELLOW: ns_light = LIGHT_YELLOW;
            EW_GREEN:  ew_light = LIGHT_GREEN;
            EW_YELLOW: ew_light = LIGHT_YELLOW;
            default:   ;
        endcase
    end

    assign phase = state;

    approach_wait_counter u_ns_wait (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .car      (ns_car),
        .is_green (state == NS_GREEN),
        .clear    (state_change && next_state == NS_GREEN),
        .count    (ns_wait)
    );

    approach_wait_counter u_ew_wait (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .car      (ew_car),
        .is_green (state == EW_GREEN),
        .clear    (state_change && next_state == EW_GREEN),
        .count    (ew_wait)
    );

endmodule

// File: tb/tb_tlc_phase_scheduler.sv
// Scoreboard bench for tlc_phase_scheduler against a phase/direction-level reference model.
`timescale 1ns/1ps
module tb_tlc_phase_scheduler;

    localparam int MIN_G = 4;
    localparam int MAX_G = 12;
    localparam int YEL   = 3;
    localparam int ARED  = 1;

    typedef struct packed {
        logic [2:0] phase;
        logic [2:0] ns_light;
        logic [2:0] ew_light;
        logic [2:0] ns_wait;
        logic [2:0] ew_wait;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       ns_car = 1'b0;
    logic       ew_car = 1'b0;
    logic [2:0] ns_light, ew_light, ns_wait, ew_wait, phase;

    int n_vec = 0;
    int n_bad = 0;
    obs_t exp_q[$];

    // Model: direction owning the cycle (0 NS, 1 EW), stage (0 green, 1 yellow,
    // 2 all-red), ticks spent in the stage, and the two demand counts.
    int m_dir, m_kind, m_cnt, m_ns, m_ew;

    tlc_phase_scheduler #(
        .MIN_GREEN     (MIN_G),
        .MAX_GREEN     (MAX_G),
        .YELLOW_TICKS  (YEL),
        .ALL_RED_TICKS (ARED)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .ns_car   (ns_car),
        .ew_car   (ew_car),
        .ns_light (ns_light),
        .ew_light (ew_light),
        .ns_wait  (ns_wait),
        .ew_wait  (ew_wait),
        .phase    (phase)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] light_of(input int approach);
        if (approach != m_dir || m_kind == 2) return 3'b100;
        return (m_kind == 0) ? 3'b001 : 3'b010;
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.phase    = 3'(m_dir * 3 + m_kind);
        o.ns_light = light_of(0);
        o.ew_light = light_of(1);
        o.ns_wait  = 3'(m_ns);
        o.ew_wait  = 3'(m_ew);
        return o;
    endfunction

    function automatic obs_t dut_obs();
        obs_t o;
        o.phase    = phase;
        o.ns_light = ns_light;
        o.ew_light = ew_light;
        o.ns_wait  = ns_wait;
        o.ew_wait  = ew_wait;
        return o;
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s @%0t: got phase=%0d ns=%b ew=%b nw=%0d ew_w=%0d, want phase=%0d ns=%b ew=%b nw=%0d ew_w=%0d",
                     name, $time, got.phase, got.ns_light, got.ew_light, got.ns_wait, got.ew_wait,
                     want.phase, want.ns_light, want.ew_light, want.ns_wait, want.ew_wait);
        end
    endtask

    task automatic model_reset();
        m_dir = 0; m_kind = 0; m_cnt = 0; m_ns = 0; m_ew = 0;
    endtask

    // Drive one cycle of inputs, advance the model, queue the expected response.
    task automatic step(input bit t, input bit ns, input bit ew);
        int  n, opp, nd, nk;
        bit  chg;
        @(negedge clk);
        tick = t; ns_car = ns; ew_car = ew;
        if (t) begin
            nd  = m_dir;
            nk  = m_kind;
            n   = m_cnt + 1;
            opp = (m_dir == 0) ? m_ew : m_ns;
            case (m_kind)
                0: if ((n >= MIN_G && opp == 4) || (n >= MAX_G && opp != 0)) nk = 1;
                1: if (n == YEL) nk = 2;
                default: if (n == ARED) begin nk = 0; nd = 1 - m_dir; end
            endcase
            chg = (nd != m_dir) || (nk != m_kind);
            if (chg && nk == 0 && nd == 0)             m_ns = 0;
            else if (!(m_kind == 0 && m_dir == 0) && ns) m_ns = (m_ns >= 4) ? 4 : m_ns + 1;
            if (chg && nk == 0 && nd == 1)             m_ew = 0;
            else if (!(m_kind == 0 && m_dir == 1) && ew) m_ew = (m_ew >= 4) ? 4 : m_ew + 1;
            m_cnt  = chg ? 0 : m_cnt + 1;
            m_dir  = nd;
            m_kind = nk;
        end
        exp_q.push_back(model_obs());
    endtask

    // Asynchronous reset pulse mid-cycle; outputs must return to reset values before the next edge.
    task automatic pulse_reset(input string name);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check(name, dut_obs(), model_obs());
        #1 reset = 1'b0;
    endtask

    task automatic drive_until(input int dir, input int kind, input bit ns, input bit ew, input string name);
        for (int i = 0; i < 40 && !(m_dir == dir && m_kind == kind); i++) step(1'b1, ns, ew);
        if (!(m_dir == dir && m_kind == kind)) begin
            n_vec++; n_bad++;
            $display("FAIL %s: target stage not reached within 40 ticks", name);
        end
    endtask

    // Monitor: one registered response per cycle, compared after the edge settles.
    initial begin
        obs_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("scoreboard", dut_obs(), e);
            end
        end
    end

    initial begin
        model_reset();
        #3;
        check("reset_state", dut_obs(), model_obs());
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Idle: NS green holds forever, timer saturates, no demand.
        repeat (40) step(1'b1, 1'b0, 1'b0);
        // Late EW demand after saturation: MAX_GREEN rule fires as soon as ew_wait != 0.
        repeat (6) step(1'b1, 1'b0, 1'b1);

        // Continuous EW demand from reset: yellow after tick 5, EW green after tick 9.
        pulse_reset("reset_before_ew_seq");
        repeat (12) step(1'b1, 1'b0, 1'b1);

        // Single EW pulse: wait holds at 1, change forced at MAX_GREEN.
        pulse_reset("reset_before_pulse");
        step(1'b1, 1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b1);
        repeat (14) step(1'b1, 1'b0, 1'b0);

        // EW green with both cars held: ns_wait climbs, ew_wait stays 0.
        pulse_reset("reset_before_ew_green");
        drive_until(1, 0, 1'b0, 1'b1, "reach_ew_green");
        repeat (8) step(1'b1, 1'b1, 1'b1);

        // Tick low: nothing moves, whatever the sensors say.
        repeat (10) step(1'b0, 1'b1, 1'b1);
        repeat (3) step(1'b1, 1'b1, 1'b1);

        // Reset mid NS_YELLOW: immediate return, sequence restarts from NS green.
        pulse_reset("reset_before_yellow");
        drive_until(0, 1, 1'b0, 1'b1, "reach_ns_yellow");
        step(1'b1, 1'b0, 1'b1);
        pulse_reset("reset_mid_yellow");
        repeat (4) step(1'b1, 1'b0, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 499) == 0) pulse_reset("random_reset");
        end

        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_vec++; n_bad++;
            $display("FAIL drain: %0d expected responses never compared", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
